// File: rtl/framebuffer_row_fetch.sv
// Prefetches one panel row pair into a ping-pong line buffer and serves it to the
// HUB75 data pins one column per load, bit-plane selected by the brightness mask.
module framebuffer_row_fetch #(
  parameter int COLUMNS     = 64,
  parameter int ROW_BITS    = 4,
  parameter int RAM_LATENCY = 1
) (
  input  logic                              clk_in,
  input  logic                              reset,
  input  logic [ROW_BITS-1:0]               row_address,
  input  logic [$clog2(COLUMNS)-1:0]        column_address,
  input  logic [5:0]                        brightness_mask,
  input  logic                              pixel_load_en,
  output logic [ROW_BITS+$clog2(COLUMNS):0] ram_addr,
  output logic                              ram_rd_en,
  input  logic [15:0]                       ram_rd_data,
  output logic [2:0]                        rgb1,
  output logic [2:0]                        rgb2,
  output logic                              fetch_busy,
  output logic                              underrun
);
  localparam int COL_W = $clog2(COLUMNS);
  localparam int IDX_W = COL_W + 1;
  localparam int DRN_W = 2;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(2 * COLUMNS - 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(RAM_LATENCY);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;
  typedef enum logic [1:0] {BOOT_ROW0 = 2'd0, BOOT_ROW1 = 2'd1, BOOT_DONE = 2'd2} boot_t;

  // Stored pixel layout: {B6, G6, R6}, 5-bit channels widened by replicating their MSB.
  function automatic logic [17:0] expand565(input logic [15:0] p);
    return {p[4:0], p[4], p[10:5], p[15:11], p[15]};
  endfunction

  function automatic logic is_one_hot(input logic [5:0] m);
    return (m != 6'd0) && ((m & (m - 6'd1)) == 6'd0);
  endfunction

  function automatic logic [2:0] plane_bits(input logic [17:0] px, input logic [5:0] m);
    logic [2:0] bits;
    bits[0] = |(px[5:0] & m);
    bits[1] = |(px[11:6] & m);
    bits[2] = |(px[17:12] & m);
    if (!is_one_hot(m)) begin
      bits = 3'd0;
    end
    return bits;
  endfunction

  state_t              state_r, state_s;
  boot_t               boot_r, boot_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [DRN_W-1:0]    drain_r, drain_s;
  logic [ROW_BITS-1:0] fetch_row_r, fetch_row_s;
  logic [ROW_BITS-1:0] row_prev_r;
  logic [1:0]          bank_valid_r;
  logic                commit_s;
  logic                row_change_s;
  logic                wr_en_s;
  logic [RAM_LATENCY-1:0] pipe_vld_r;
  logic [IDX_W-1:0]    pipe_idx_r [RAM_LATENCY];
  logic [17:0]         line_mem_r [0:4*COLUMNS-1];
  logic [17:0]         top_px_s, bot_px_s;

  assign row_change_s = (row_address != row_prev_r);
  assign wr_en_s      = pipe_vld_r[RAM_LATENCY-1] && !row_change_s;
  assign top_px_s     = line_mem_r[{row_address[0], column_address, 1'b0}];
  assign bot_px_s     = line_mem_r[{row_address[0], column_address, 1'b1}];

  // Fetch sequencer next state; a row change aborts and restarts from index 0.
  always_comb begin
    state_s     = state_r;
    boot_s      = boot_r;
    idx_s       = idx_r;
    drain_s     = drain_r;
    fetch_row_s = fetch_row_r;
    commit_s    = 1'b0;
    if (row_change_s) begin
      state_s     = FETCH;
      idx_s       = '0;
      fetch_row_s = row_address + ROW_BITS'(1);
      boot_s      = BOOT_DONE;
    end else begin
      case (state_r)
        IDLE: begin
          if (boot_r != BOOT_DONE) begin
            state_s     = FETCH;
            idx_s       = '0;
            fetch_row_s = (boot_r == BOOT_ROW1) ? ROW_BITS'(1) : ROW_BITS'(0);
          end else begin
            state_s = IDLE;
          end
        end
        FETCH: begin
          if (idx_r == LAST_IDX) begin
            state_s = DRAIN;
            drain_s = '0;
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end
        DRAIN: begin
          // RAM_LATENCY cycles for the last writes, then one cycle to publish the bank.
          if (drain_r == DRAIN_LAST) begin
            state_s  = IDLE;
            commit_s = 1'b1;
            if (boot_r == BOOT_ROW0) begin
              boot_s = BOOT_ROW1;
            end else begin
              boot_s = BOOT_DONE;
            end
          end else begin
            drain_s = drain_r + DRN_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Sequencer state, row tracking and per-bank validity.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      boot_r       <= BOOT_ROW0;
      idx_r        <= '0;
      drain_r      <= '0;
      fetch_row_r  <= '0;
      row_prev_r   <= '0;
      bank_valid_r <= 2'b00;
    end else begin
      state_r     <= state_s;
      boot_r      <= boot_s;
      idx_r       <= idx_s;
      drain_r     <= drain_s;
      fetch_row_r <= fetch_row_s;
      row_prev_r  <= row_address;
      if (row_change_s) begin
        bank_valid_r[~row_address[0]] <= 1'b0;
      end else if (commit_s) begin
        bank_valid_r[fetch_row_r[0]] <= 1'b1;
      end
    end
  end

  // RAM request outputs, registered from the next-state decode.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      ram_rd_en  <= 1'b0;
      ram_addr   <= '0;
      fetch_busy <= 1'b0;
    end else begin
      ram_rd_en  <= (state_s == FETCH);
      fetch_busy <= (state_s == FETCH) || (state_s == DRAIN);
      if (state_s == FETCH) begin
        ram_addr <= {idx_s[0], fetch_row_s, idx_s[IDX_W-1:1]};
      end else begin
        ram_addr <= '0;
      end
    end
  end

  // Read-return index pipeline; flushed on a row change so aborted reads never land.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pipe_vld_r <= '0;
      for (int s = 0; s < RAM_LATENCY; s++) begin
        pipe_idx_r[s] <= '0;
      end
    end else if (row_change_s) begin
      pipe_vld_r <= '0;
    end else begin
      pipe_vld_r[0] <= ram_rd_en;
      pipe_idx_r[0] <= idx_r;
      for (int s = 1; s < RAM_LATENCY; s++) begin
        pipe_vld_r[s] <= pipe_vld_r[s-1];
        pipe_idx_r[s] <= pipe_idx_r[s-1];
      end
    end
  end

  // Line-buffer write port; contents are not reset, bank_valid_r guards their use.
  always_ff @(posedge clk_in) begin
    if (wr_en_s) begin
      line_mem_r[{fetch_row_r[0], pipe_idx_r[RAM_LATENCY-1]}] <= expand565(ram_rd_data);
    end
  end

  // Pixel output registers; an invalid display bank forces black and latches underrun.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rgb1     <= 3'd0;
      rgb2     <= 3'd0;
      underrun <= 1'b0;
    end else if (pixel_load_en) begin
      if (bank_valid_r[row_address[0]]) begin
        rgb1 <= plane_bits(top_px_s, brightness_mask);
        rgb2 <= plane_bits(bot_px_s, brightness_mask);
      end else begin
        rgb1     <= 3'd0;
        rgb2     <= 3'd0;
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_row_fetch.sv
// Self-checking bench for framebuffer_row_fetch: a latency-1 RAM holding random pixels and
// a bank/row scoreboard that predicts every bit-plane load from the RAM contents.
`timescale 1ns/1ps
module tb_framebuffer_row_fetch;
  logic        clk_in = 1'b0;
  logic        reset;
  logic [3:0]  row_address;
  logic [5:0]  column_address;
  logic [5:0]  brightness_mask;
  logic        pixel_load_en;
  logic [10:0] ram_addr;
  logic        ram_rd_en;
  logic [15:0] ram_rd_data = 16'h0000;
  logic [2:0]  rgb1, rgb2;
  logic        fetch_busy, underrun;

  logic [15:0] ram_mem [0:2047];
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;
  int          bank_row [2];
  bit          bank_ok [2];
  logic [2:0]  last1, last2;
  int          busy_cycles;
  logic [10:0] addr_q [$];

  framebuffer_row_fetch #(.COLUMNS(64), .ROW_BITS(4), .RAM_LATENCY(1)) dut (
    .clk_in(clk_in), .reset(reset), .row_address(row_address),
    .column_address(column_address), .brightness_mask(brightness_mask),
    .pixel_load_en(pixel_load_en), .ram_addr(ram_addr), .ram_rd_en(ram_rd_en),
    .ram_rd_data(ram_rd_data), .rgb1(rgb1), .rgb2(rgb2),
    .fetch_busy(fetch_busy), .underrun(underrun)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (ram_rd_en) ram_rd_data <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: widen channels to 6 bits, then pick the single plane named by the mask.
  function automatic logic [2:0] exp_rgb(input logic [15:0] p, input logic [5:0] m);
    int k, r6, g6, b6;
    logic [2:0] res;
    if ($countones(m) != 1) return 3'b000;
    k = 0;
    for (int j = 0; j < 6; j++) if (m[j]) k = j;
    r6 = int'(p[15:11]) * 2 + int'(p[15]);
    g6 = int'(p[10:5]);
    b6 = int'(p[4:0]) * 2 + int'(p[4]);
    res[0] = ((r6 >> k) & 1) == 1;
    res[1] = ((g6 >> k) & 1) == 1;
    res[2] = ((b6 >> k) & 1) == 1;
    return res;
  endfunction

  task automatic load_check(input logic [5:0] col, input logic [5:0] mask, input string tag);
    logic [2:0] e1, e2;
    int b;
    b = int'(row_address[0]);
    if (!bank_ok[b]) begin
      e1 = 3'b000;
      e2 = 3'b000;
    end else begin
      e1 = exp_rgb(ram_mem[{1'b0, 4'(bank_row[b]), col}], mask);
      e2 = exp_rgb(ram_mem[{1'b1, 4'(bank_row[b]), col}], mask);
    end
    column_address = col;
    brightness_mask = mask;
    pixel_load_en = 1'b1;
    @(negedge clk_in);
    pixel_load_en = 1'b0;
    check({tag, "_rgb1"}, 32'(rgb1), 32'(e1));
    check({tag, "_rgb2"}, 32'(rgb2), 32'(e2));
    last1 = e1;
    last2 = e2;
  endtask

  task automatic rand_loads(input int n, input string tag);
    logic [5:0] m;
    for (int i = 0; i < n; i++) begin
      m = 6'(1 << $urandom_range(5));
      if ($urandom_range(7) == 0) m = 6'($urandom);
      load_check(6'($urandom_range(63)), m, tag);
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) ram_mem[a] = 16'($urandom);
    ram_mem[{1'b0, 4'd0, 6'd5}]  = 16'hF800;
    ram_mem[{1'b1, 4'd0, 6'd63}] = 16'h07E0;
    ram_mem[{1'b1, 4'd0, 6'd62}] = 16'h0000;
    bank_ok[0] = 1'b0;
    bank_ok[1] = 1'b0;
    bank_row[0] = 0;
    bank_row[1] = 0;
    reset = 1'b1;
    row_address = 4'd1;
    column_address = 6'd0;
    brightness_mask = 6'd1;
    pixel_load_en = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_rgb1", 32'(rgb1), 32'd0);
    check("rst_rgb2", 32'(rgb2), 32'd0);
    check("rst_rd_en", 32'(ram_rd_en), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);

    // Row change right at reset release: display bank 1 is never valid.
    reset = 1'b0;
    load_check(6'd3, 6'b000001, "inv_load");
    check("inv_underrun", 32'(underrun), 32'd1);
    repeat (200) @(negedge clk_in);
    load_check(6'd9, 6'b000100, "inv_load2");
    check("underrun_sticky", 32'(underrun), 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_underrun", 32'(underrun), 32'd0);
    check("async_rst_busy", 32'(fetch_busy), 32'd0);
    row_address = 4'd0;
    @(negedge clk_in);

    // Boot: row 0 into bank 0, then row 1 into bank 1.
    reset = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_in);
      if (fetch_busy) busy_cycles++;
      if (ram_rd_en) addr_q.push_back(ram_addr);
    end
    check("boot_busy_cycles", 32'(busy_cycles), 32'd260);
    check("boot_read_count", 32'(addr_q.size()), 32'd256);
    for (int k = 0; k < 256 && k < addr_q.size(); k++) begin
      check("boot_addr", 32'(addr_q[k]), 32'(((k % 128) & 1) * 1024 + (k / 128) * 64 + (k % 128) / 2));
    end
    bank_ok[0] = 1'b1; bank_row[0] = 0;
    bank_ok[1] = 1'b1; bank_row[1] = 1;

    load_check(6'd5, 6'b100000, "red_msb");
    check("red_msb_exact", 32'(rgb1), 32'd1);
    load_check(6'd5, 6'b000001, "red_lsb_repl");
    check("red_lsb_exact", 32'(rgb1), 32'd1);
    load_check(6'd63, 6'b000001, "green_col63");
    check("green_col63_exact", 32'(rgb2), 32'd2);
    load_check(6'd62, 6'b010000, "black");
    load_check(6'd5, 6'b000000, "mask_zero");
    load_check(6'd5, 6'b000011, "mask_two_hot");
    rand_loads(30, "row0");

    load_check(6'd5, 6'b100000, "pre_hold");
    column_address = 6'd40;
    brightness_mask = 6'b000010;
    repeat (4) @(negedge clk_in);
    check("hold_rgb1", 32'(rgb1), 32'(last1));
    check("hold_rgb2", 32'(rgb2), 32'(last2));

    // Row 0 -> 1: fetch row 2 into bank 0, display stays on bank 1.
    row_address = 4'd1;
    bank_ok[0] = 1'b0;
    @(negedge clk_in);
    check("r1_rd_en", 32'(ram_rd_en), 32'd1);
    check("r1_addr", 32'(ram_addr), 32'h080);
    check("r1_busy", 32'(fetch_busy), 32'd1);
    rand_loads(10, "row1");
    repeat (140) @(negedge clk_in);
    bank_ok[0] = 1'b1; bank_row[0] = 2;

    // Row 1 -> 2 starts row 3 into bank 1; jump to row 4 at index 40 retargets row 5.
    row_address = 4'd2;
    bank_ok[1] = 1'b0;
    repeat (41) @(negedge clk_in);
    check("i40_addr", 32'(ram_addr), 32'((3 << 6) | 20));
    check("i40_rd_en", 32'(ram_rd_en), 32'd1);
    row_address = 4'd4;
    @(negedge clk_in);
    check("abort_addr", 32'(ram_addr), 32'(5 << 6));
    check("abort_rd_en", 32'(ram_rd_en), 32'd1);
    rand_loads(10, "row2_bank0");
    repeat (140) @(negedge clk_in);
    bank_ok[1] = 1'b1; bank_row[1] = 5;
    row_address = 4'd5;
    bank_ok[0] = 1'b0;
    rand_loads(40, "row5_after_abort");
    repeat (140) @(negedge clk_in);
    bank_ok[0] = 1'b1; bank_row[0] = 6;

    // Wrap: row 15 fetches row 0, row 0 fetches row 1.
    row_address = 4'd15;
    bank_ok[0] = 1'b0;
    @(negedge clk_in);
    check("r15_addr", 32'(ram_addr), 32'h000);
    check("r15_rd_en", 32'(ram_rd_en), 32'd1);
    repeat (140) @(negedge clk_in);
    bank_ok[0] = 1'b1; bank_row[0] = 0;
    row_address = 4'd0;
    bank_ok[1] = 1'b0;
    @(negedge clk_in);
    check("wrap_addr", 32'(ram_addr), 32'h040);
    check("wrap_rd_en", 32'(ram_rd_en), 32'd1);
    rand_loads(10, "row0_again");
    check("final_underrun", 32'(underrun), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
